// File: rtl/fsm_if_pkg.sv
// Shared types and constants for the FSM_IF target-side receiver.
package fsm_if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } rx_state_t;

    localparam int SYNC_STAGES   = 2;
    localparam int MIN_CLK_RATIO = 4;

    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/fsm_if_rx_fifo.sv
// First-word-fall-through FIFO holding committed receive words.
module fsm_if_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = push & (~full | pop);
    assign w_do_pop  = pop & ~empty;
    assign head      = r_mem[r_rd_ptr[AW-1:0]];

    // Read/write pointer update with flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else if (flush) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage array write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= {DATA_W{1'b0}};
        end else if (w_do_push && !flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fsm_if_rx.sv
// FSM_IF receiver: synchronizes the test strobes, deserializes words, queues them for the core.
// Optional even-parity word check is enabled by defining FSM_IF_RX_PARITY_EN.
module fsm_if_rx
    import fsm_if_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tclk,
    input  logic              trst,
    input  logic              sr_en,
    input  logic              dq_en,
    input  logic              tdi,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overflow,
    output logic              par_err
);
`ifdef FSM_IF_RX_PARITY_EN
    localparam int N_BITS = DATA_W + 1;
`else
    localparam int N_BITS = DATA_W;
`endif
    localparam int CW = $clog2(N_BITS + 1);

    logic [SYNC_STAGES-1:0][4:0] r_sync;
    logic [4:0]        w_sync;
    logic              w_tclk_s, w_trst_s, w_sr_s, w_dq_s, w_tdi_s;
    logic              r_tclk_d;
    logic              w_tick;
    rx_state_t         r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [N_BITS-1:0] r_shreg, w_shreg_nxt, w_shifted;
    logic [DATA_W-1:0] w_payload;
    logic              w_par_ok;
    logic              w_push_nxt, w_frame_err_nxt, w_par_err_nxt;
    logic              r_push;
    logic [DATA_W-1:0] r_push_data;
    logic              r_frame_err, r_par_err, r_overflow;
    logic              w_empty, w_full, w_pop;
    logic [DATA_W-1:0] w_head;

    assign {w_tclk_s, w_trst_s, w_sr_s, w_dq_s, w_tdi_s} = w_sync;
    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_tick    = w_tclk_s & ~r_tclk_d;
    assign w_cnt_inc = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    // Bits arrive LSB first, so each new bit enters at the top and slides down.
    assign w_shifted = {w_tdi_s, r_shreg[N_BITS-1:1]};
    assign w_payload = r_shreg[DATA_W-1:0];
`ifdef FSM_IF_RX_PARITY_EN
    assign w_par_ok  = (r_shreg[N_BITS-1] == even_parity(32'(w_payload)));
`else
    assign w_par_ok  = 1'b1;
`endif

    // Pin synchronizers and registered tclk for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_tclk_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], tclk, trst, sr_en, dq_en, tdi};
            r_tclk_d <= w_tclk_s;
        end
    end

    // Receive FSM next state, shift/count update and event pulses
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shreg_nxt     = r_shreg;
        w_push_nxt      = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_par_err_nxt   = 1'b0;
        if (w_trst_s) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = {CW{1'b0}};
            w_shreg_nxt = {N_BITS{1'b0}};
        end else if (w_tick) begin
            if (w_sr_s && w_dq_s) begin
                w_frame_err_nxt = 1'b1;
                w_state_nxt     = ERR;
            end else if (w_dq_s) begin
                if (r_state == HOLD) begin
                    if (w_par_ok) w_push_nxt = 1'b1;
                    else          w_par_err_nxt = 1'b1;
                end else begin
                    w_frame_err_nxt = 1'b1;
                end
                w_state_nxt = IDLE;
                w_cnt_nxt   = {CW{1'b0}};
                w_shreg_nxt = {N_BITS{1'b0}};
            end else if (w_sr_s) begin
                case (r_state)
                    IDLE, SHIFT: begin
                        w_shreg_nxt = w_shifted;
                        w_cnt_nxt   = w_cnt_inc;
                        w_state_nxt = (w_cnt_inc == CW'(N_BITS)) ? HOLD : SHIFT;
                    end
                    HOLD:    w_state_nxt = ERR;
                    ERR:     w_state_nxt = ERR;
                    default: w_state_nxt = IDLE;
                endcase
            end else begin
                w_state_nxt = r_state;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM, datapath and output event registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= {CW{1'b0}};
            r_shreg     <= {N_BITS{1'b0}};
            r_push      <= 1'b0;
            r_push_data <= {DATA_W{1'b0}};
            r_frame_err <= 1'b0;
            r_par_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shreg     <= w_shreg_nxt;
            r_push      <= w_push_nxt;
            r_push_data <= w_payload;
            r_frame_err <= w_frame_err_nxt;
            r_par_err   <= w_par_err_nxt;
        end
    end

    // Sticky overflow: judged when the push reaches the FIFO so a same-cycle pop still makes room
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_trst_s) begin
            r_overflow <= 1'b0;
        end else if (r_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign w_pop = out_ready & ~w_empty;

    fsm_if_rx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (w_trst_s),
        .push      (r_push),
        .push_data (r_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full)
    );

    assign out_data  = w_head;
    assign out_valid = ~w_empty;
    assign frame_err = r_frame_err;
    assign par_err   = r_par_err;
    assign overflow  = r_overflow;

endmodule
